// File: rtl/traffic_controller_ndir_if.sv
// traffic_controller_ndir_if: demand/flash inputs and lamp/status outputs of the N-direction traffic controller
// Signals: req, flash (towards controller); red, yellow, green, active_dir, pending (from controller).
// Modports: master (stimulus side), slave (controller side).
interface traffic_controller_ndir_if #(
  parameter int NUM_DIR = 4
) ();
  logic [NUM_DIR-1:0]         req;
  logic                       flash;
  logic [NUM_DIR-1:0]         red;
  logic [NUM_DIR-1:0]         yellow;
  logic [NUM_DIR-1:0]         green;
  logic [$clog2(NUM_DIR)-1:0] active_dir;
  logic [NUM_DIR-1:0]         pending;
  modport master (output req, flash, input red, yellow, green, active_dir, pending);
  modport slave  (input req, flash, output red, yellow, green, active_dir, pending);
endinterface

// File: rtl/traffic_controller_ndir.sv
// traffic_controller_ndir: tick-timed ALL_RED/GREEN/YELLOW controller serving NUM_DIR directions on demand
// Ports: clk, reset (sync, active-high); bus (slave): req/flash in, red/yellow/green/active_dir/pending out.
// Option: define TRAFFIC_FLASH_EN to add the FLASH state (all yellow lamps blink per tick while flash=1).
module traffic_controller_ndir #(
  parameter int NUM_DIR      = 4,
  parameter int TICK_DIV     = 10_000_000,
  parameter int GREEN_TICKS  = 30,
  parameter int YELLOW_TICKS = 3,
  parameter int ALLRED_TICKS = 1
) (
  input logic                    clk,
  input logic                    reset,
  traffic_controller_ndir_if.slave bus
);
  localparam int DW   = $clog2(NUM_DIR);
  localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MAXD = (GREEN_TICKS > YELLOW_TICKS) ?
                        ((GREEN_TICKS > ALLRED_TICKS) ? GREEN_TICKS : ALLRED_TICKS) :
                        ((YELLOW_TICKS > ALLRED_TICKS) ? YELLOW_TICKS : ALLRED_TICKS);
  localparam int CW   = (MAXD > 1) ? $clog2(MAXD) : 1;
  localparam logic [CW-1:0] G_M1 = CW'(GREEN_TICKS - 1);
  localparam logic [CW-1:0] Y_M1 = CW'(YELLOW_TICKS - 1);
  localparam logic [CW-1:0] A_M1 = CW'(ALLRED_TICKS - 1);

  typedef enum logic [1:0] {
    ST_ALL_RED,
    ST_GREEN,
    ST_YELLOW
`ifdef TRAFFIC_FLASH_EN
    , ST_FLASH
`endif
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [PW-1:0]      r_presc;
  logic [CW-1:0]      r_phase, w_phase_nxt, w_dur_m1;
  logic [DW-1:0]      r_dir, w_dir_nxt, w_sel;
  logic [NUM_DIR-1:0] r_pending, w_pending_nxt, w_onehot;
  logic               w_tick, w_other, w_flash, w_tog;

  function automatic logic [DW-1:0] f_wrap(input logic [DW-1:0] d, input int k);
    return DW'((int'(d) + k) % NUM_DIR);
  endfunction

  assign w_tick   = r_presc == PW'(TICK_DIV - 1);
  assign w_onehot = NUM_DIR'(1) << r_dir;
  assign w_other  = |(r_pending & ~w_onehot);
  assign w_dur_m1 = (r_state == ST_GREEN) ? G_M1 : (r_state == ST_YELLOW) ? Y_M1 : A_M1;
  // Serving clears the active direction's demand; the clear beats a same-cycle request.
  assign w_pending_nxt = (r_pending | bus.req) & ~((r_state == ST_GREEN) ? w_onehot : '0);

  // Circular search from active_dir+1 through active_dir; descending k lets the nearest hit win.
  always_comb begin
    w_sel = f_wrap(r_dir, 1);
    for (int k = NUM_DIR; k >= 1; k--)
      if (|(r_pending & (NUM_DIR'(1) << f_wrap(r_dir, k)))) w_sel = f_wrap(r_dir, k);
  end

`ifdef TRAFFIC_FLASH_EN
  logic r_tog, w_tog_nxt;
  assign w_flash = r_state == ST_FLASH;
  assign w_tog   = r_tog;
`else
  logic w_unused_flash;
  assign w_unused_flash = bus.flash;
  assign w_flash = 1'b0;
  assign w_tog   = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_dir_nxt   = r_dir;
    if (w_tick) begin
      if (r_phase != w_dur_m1) w_phase_nxt = r_phase + 1'b1;
      else begin
        w_phase_nxt = '0;
        case (r_state)
          ST_ALL_RED: begin
            w_state_nxt = ST_GREEN;
            w_dir_nxt   = w_sel;
          end
          ST_GREEN:  w_state_nxt = w_other ? ST_YELLOW : ST_GREEN;
          ST_YELLOW: w_state_nxt = ST_ALL_RED;
          default:   w_state_nxt = r_state;
        endcase
      end
    end
`ifdef TRAFFIC_FLASH_EN
    w_tog_nxt = r_tog ^ w_tick;
    if (r_state == ST_FLASH) begin
      w_state_nxt = bus.flash ? ST_FLASH : ST_ALL_RED;
      w_phase_nxt = '0;
      w_dir_nxt   = r_dir;
    end else if (bus.flash) begin
      w_state_nxt = ST_FLASH;
      w_phase_nxt = '0;
      w_dir_nxt   = r_dir;
      w_tog_nxt   = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_ALL_RED;
      r_presc   <= '0;
      r_phase   <= '0;
      r_dir     <= DW'(NUM_DIR - 1);
      r_pending <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_presc   <= w_tick ? '0 : r_presc + 1'b1;
      r_phase   <= w_phase_nxt;
      r_dir     <= w_dir_nxt;
      r_pending <= w_pending_nxt;
    end
  end

`ifdef TRAFFIC_FLASH_EN
  always_ff @(posedge clk) r_tog <= reset ? 1'b0 : w_tog_nxt;
`endif

  assign bus.green      = (r_state == ST_GREEN) ? w_onehot : '0;
  assign bus.yellow     = w_flash ? {NUM_DIR{w_tog}} : (r_state == ST_YELLOW) ? w_onehot : '0;
  assign bus.red        = w_flash ? '0 : (r_state == ST_ALL_RED) ? '1 : ~w_onehot;
  assign bus.active_dir = r_dir;
  assign bus.pending    = r_pending;
endmodule

// File: tb/tb_traffic_controller_ndir.sv
// tb_traffic_controller_ndir: randomized scoreboard bench against a tick-level behavioural model
module tb_traffic_controller_ndir;
  localparam int N = 4, TD = 4, GT = 3, YT = 2, AT = 1;
  logic clk = 1'b0;
  logic reset = 1'b1;
  traffic_controller_ndir_if #(.NUM_DIR(N)) bus ();
  traffic_controller_ndir #(.NUM_DIR(N), .TICK_DIV(TD), .GREEN_TICKS(GT), .YELLOW_TICKS(YT),
    .ALLRED_TICKS(AT)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  typedef struct packed {logic [N-1:0] r, y, g, p; logic [1:0] a;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;

  // model: st 0=all-red 1=green 2=yellow 3=flash; left = ticks remaining in phase
  int st, dir, left, n;
  bit tog;
  bit [N-1:0] p;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic model_step(input bit rs, input bit [N-1:0] rq, input bit fl);
    bit tick;
    bit [N-1:0] pold, oh;
    int sel;
    if (rs) begin
      st = 0; dir = N - 1; left = AT; n = 0; p = '0; tog = 0;
      return;
    end
    tick = (n % TD) == TD - 1;
    n = (n + 1) % TD;
    pold = p;
    oh = 4'b1 << dir;
    p = (p | rq) & ~((st == 1) ? oh : 4'b0);
`ifdef TRAFFIC_FLASH_EN
    if (fl) begin
      if (st != 3) begin st = 3; tog = 0; end
      else if (tick) tog = ~tog;
      return;
    end
    if (st == 3) begin st = 0; left = AT; return; end
`endif
    if (!tick) return;
    left--;
    if (left != 0) return;
    if (st == 0) begin
      sel = (dir + 1) % N;
      for (int k = N; k >= 1; k--) if (pold[(dir + k) % N]) sel = (dir + k) % N;
      dir = sel; st = 1; left = GT;
    end else if (st == 1) begin
      if ((pold & ~oh) != 0) begin st = 2; left = YT; end
      else left = GT;
    end else begin
      st = 0; left = AT;
    end
  endtask

  function automatic exp_t expected();
    exp_t e;
    bit [N-1:0] oh;
    oh = 4'b1 << dir;
    e.g = (st == 1) ? oh : 4'b0;
    e.y = (st == 2) ? oh : (st == 3) ? {N{tog}} : 4'b0;
    e.r = (st == 0) ? 4'hF : (st == 3) ? 4'b0 : ~oh;
    e.p = p;
    e.a = 2'(dir);
    return e;
  endfunction

  initial begin
    bit rs, fl;
    bit [N-1:0] rq;
    bus.req = '0;
    bus.flash = 1'b0;
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      rs = c < 3 || (c >= 400 && $urandom_range(299) == 0);
      rq = '0;
      if (c == 230 || c == 231) rq = 4'b0100;
      else if (c >= 400 && c < 3000) for (int i = 0; i < N; i++) rq[i] = $urandom_range(19) == 0;
      else if (c >= 3000 && c < 3600) rq = (st == 1) ? 4'(4'b1 << dir) : 4'b0;
      else if (c >= 3600) for (int i = 0; i < N; i++) rq[i] = $urandom_range(11) == 0;
      fl = c >= 4500 && (c % 400) < 60;
      reset = rs;
      bus.req = rq;
      bus.flash = fl;
      model_step(rs, rq, fl);
      q.push_back(expected());
    end
    @(negedge clk);
    @(negedge clk);
    chk("drain", 8'(q.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("red", 8'(bus.red), 8'(e.r));
        chk("yellow", 8'(bus.yellow), 8'(e.y));
        chk("green", 8'(bus.green), 8'(e.g));
        chk("pending", 8'(bus.pending), 8'(e.p));
        chk("active_dir", 8'(bus.active_dir), 8'(e.a));
      end
    end
  end
endmodule

// File: doc/traffic_controller_ndir.md
TRAFFIC_CONTROLLER_NDIR -- requirements
Module: traffic_controller_ndir

Interface
REQ-001 SHALL have parameter NUM_DIR, default 4, meaning number of approach directions (legal 2..8).
REQ-002 SHALL have parameter TICK_DIV, default 10_000_000, meaning clk cycles per timing tick (legal >=1).
REQ-003 SHALL have parameter GREEN_TICKS, default 30, meaning green phase length in ticks (legal >=1).
REQ-004 SHALL have parameter YELLOW_TICKS, default 3, meaning yellow phase length in ticks (legal >=1).
REQ-005 SHALL have parameter ALLRED_TICKS, default 1, meaning all-red clearance length in ticks (legal >=1).
REQ-006 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port req  input  NUM_DIR  per-direction demand; a level high for one clk registers demand.
REQ-009 SHALL have port flash  input  1  flash-mode request; used only when FLASH_EN is defined.
REQ-010 SHALL have port red  output  NUM_DIR  per-direction red lamp.
REQ-011 SHALL have port yellow  output  NUM_DIR  per-direction yellow lamp.
REQ-012 SHALL have port green  output  NUM_DIR  per-direction green lamp.
REQ-013 SHALL have port active_dir  output  clog2(NUM_DIR)  direction currently or last served.
REQ-014 SHALL have port pending  output  NUM_DIR  registered sticky demand flags.

Function
REQ-015 SHALL run a free prescaler counting 0..TICK_DIV-1 and wrapping, asserting the internal tick for exactly the one cycle where count==TICK_DIV-1; with TICK_DIV=1 the tick is high every cycle.
REQ-016 SHALL implement the states ALL_RED, GREEN and YELLOW (plus FLASH under FLASH_EN), with a phase counter cleared to 0 on every state entry.
REQ-017 SHALL, on a tick, advance the phase counter when it is below DUR-1 and take the exit transition when it equals DUR-1, so each phase lasts exactly DUR ticks.
REQ-018 SHALL set pending[i] in any cycle where req[i]=1, holding it until served; pending[active_dir] SHALL be forced to 0 every cycle in GREEN, and the clear SHALL win over a simultaneous set.
REQ-019 SHALL, on ALL_RED exit, select the first direction with pending=1, searching circularly from active_dir+1 to active_dir inclusive; if none is pending it SHALL select (active_dir+1) mod NUM_DIR; then active_dir <= selection and state <= GREEN.
REQ-020 SHALL, on GREEN exit, go to YELLOW if any pending[j], j!=active_dir, is set; otherwise it SHALL remain GREEN with the phase counter restarted at 0 (green rest).
REQ-021 SHALL, on YELLOW exit, go to ALL_RED.
REQ-022 SHALL drive green[active_dir]=1 in GREEN and yellow[active_dir]=1 in YELLOW, with every other direction red=1; in ALL_RED all red=1; at most one green or yellow bit is ever set.
REQ-023 SHALL size the phase counter to hold max(GREEN_TICKS, YELLOW_TICKS, ALLRED_TICKS)-1 with no overflow, and wrap the direction search modulo NUM_DIR for non-power-of-2 values.

Reset
REQ-024 SHALL, while reset=1 at a clk edge, set state=ALL_RED, active_dir=NUM_DIR-1, prescaler=0, phase counter=0 and pending=0; outputs SHALL then be red all-ones, yellow 0, green 0.
REQ-025 SHALL let reset asserted mid-phase, including mid-GREEN, abort the phase immediately with no yellow; the first green after reset SHALL occur no earlier than ALLRED_TICKS ticks later.

Configuration
REQ-026 SHALL, with macro TRAFFIC_FLASH_EN defined, enter FLASH from any state at the clk edge where flash=1; in FLASH red=0, green=0, and every yellow bit equals a toggle bit that is cleared on entry and inverts on each tick; pending keeps accumulating.
REQ-027 SHALL, with TRAFFIC_FLASH_EN defined, leave FLASH for ALL_RED with phase counter 0 on the first edge where flash=0.
REQ-028 SHALL, without TRAFFIC_FLASH_EN, keep the flash port, ignore it, and omit the FLASH state and toggle logic.

Verification (NUM_DIR=4, TICK_DIV=4, GREEN_TICKS=3, YELLOW_TICKS=2, ALLRED_TICKS=1)
REQ-029 SHALL cover: release reset with req=0 -> green[0]=1 after 4 clk, then green rest holds green=0001 indefinitely.
REQ-030 SHALL cover: in GREEN dir0, pulse req[2] for 1 clk -> dir0 green for 12 clk from entry, yellow 8 clk, all-red 4 clk, then green=0100; dir1 skipped; pending[2] clears on that green.
REQ-031 SHALL cover: in GREEN dir3, set pending for dirs 0 and 1 -> after clearance active_dir wraps to 0, then dir1 is served next.
REQ-032 SHALL cover: req[active_dir] held high during GREEN -> pending[active_dir] stays 0 and no yellow is triggered.
REQ-033 SHALL cover: reset asserted in YELLOW -> next cycle red=1111, pending=0000, active_dir=3.
REQ-034 SHALL cover, with TRAFFIC_FLASH_EN: flash=1 in GREEN -> yellow toggles 0000/1111 every 4 clk; flash=0 -> red=1111 for 4 clk, then green.
